// File: rtl/rcv_shift_ctrl_if.sv
// Bus bundle between the receive controller, its shift register and the word consumer.
interface rcv_shift_ctrl_if #(
    parameter int unsigned NUM_BITS = 8
);
    logic                serial_in;
    logic [NUM_BITS-1:0] sr_data;
    logic                data_read;
    logic                sr_serial_in;
    logic                shift_enable;
    logic [NUM_BITS-1:0] rx_data;
    logic                data_ready;
    logic                framing_error;
    logic                overrun_error;

    // Environment side: drives the line, the shift register contents and the read ack.
    modport master (
        output serial_in, sr_data, data_read,
        input  sr_serial_in, shift_enable, rx_data, data_ready, framing_error, overrun_error
    );

    // Controller side.
    modport slave (
        input  serial_in, sr_data, data_read,
        output sr_serial_in, shift_enable, rx_data, data_ready, framing_error, overrun_error
    );
endinterface

// File: rtl/rcv_shift_ctrl.sv
// Start/stop-framed serial receive controller driving an external LSB-first shift register.
module rcv_shift_ctrl #(
    parameter int unsigned NUM_BITS     = 8,
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic           clk,
    input  logic           n_rst,
    rcv_shift_ctrl_if.slave bus
);
    localparam int unsigned TW      = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW      = $clog2(NUM_BITS + 1);
    localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned LAST    = CLKS_PER_BIT - 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_LOAD  = 3'd4;

    logic [2:0]          r_state;
    logic [TW-1:0]       r_timer;
    logic [CW-1:0]       r_cnt;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    logic                r_shift;
    logic [NUM_BITS-1:0] r_rx;
    logic                r_ready;
    logic                r_ferr;
    logic                r_ovr;

    logic [2:0]          w_state_next;
    logic [TW-1:0]       w_timer_next;
    logic [CW-1:0]       w_cnt_next;
    logic                w_shift_next;
    logic                w_ferr_set;
    logic                w_ferr_clr;
    logic                w_load;

    // Line synchronizer plus one extra stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= bus.serial_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // State, bit timer and bit counter registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_cnt   <= '0;
            r_shift <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
        end
    end

    // Next-state logic; the shift strobe is registered one timer tick early so it is high on the last tick.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_cnt_next   = r_cnt;
        w_ferr_set   = 1'b0;
        w_ferr_clr   = 1'b0;
        w_load       = 1'b0;
        w_shift_next = (r_state == ST_DATA) && (r_timer == TW'(LAST - 1));
        case (r_state)
            ST_IDLE: begin
                if (r_prev && !r_sync2) begin
                    w_state_next = ST_START;
                    w_timer_next = '0;
                    w_ferr_clr   = 1'b1;
                end
            end
            ST_START: begin
                if (r_timer == TW'(HALF_M1)) begin
                    if (r_sync2) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DATA;
                        w_timer_next = '0;
                        w_cnt_next   = '0;
                    end
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            ST_DATA: begin
                if (r_timer == TW'(LAST)) begin
                    w_timer_next = '0;
                    w_cnt_next   = r_cnt + CW'(1);
                    if (r_cnt == CW'(NUM_BITS - 1)) begin
                        w_state_next = ST_STOP;
                    end
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            ST_STOP: begin
                if (r_timer == TW'(LAST)) begin
                    w_timer_next = '0;
                    if (r_sync2) begin
                        w_state_next = ST_LOAD;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_ferr_set   = 1'b1;
                    end
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            ST_LOAD: begin
                w_load       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_timer_next = '0;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Received word buffer with ready/overrun handshake; a read in the load cycle acknowledges the old word.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_rx    <= '1;
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_load) begin
            r_rx    <= bus.sr_data;
            r_ready <= 1'b1;
            if (bus.data_read) begin
                r_ovr <= 1'b0;
            end else if (r_ready) begin
                r_ovr <= 1'b1;
            end
        end else if (bus.data_read) begin
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    // Framing error flag: set on a bad stop bit, cleared by the next start edge.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_ferr <= 1'b0;
        end else if (w_ferr_clr) begin
            r_ferr <= 1'b0;
        end else if (w_ferr_set) begin
            r_ferr <= 1'b1;
        end
    end

    assign bus.sr_serial_in  = r_sync2;
    assign bus.shift_enable  = r_shift;
    assign bus.rx_data       = r_rx;
    assign bus.data_ready    = r_ready;
    assign bus.framing_error = r_ferr;
    assign bus.overrun_error = r_ovr;
endmodule

// File: tb/tb_rcv_shift_ctrl.sv
// Directed bench for rcv_shift_ctrl with a behavioural LSB-first shift register alongside.
module tb_rcv_shift_ctrl;
    localparam int unsigned NB  = 8;
    localparam int unsigned CPB = 10;
    localparam int          FRAME_CYC = 10 * CPB;

    logic clk;
    logic n_rst;
    int   checks;
    int   errors;
    int   cyc;

    rcv_shift_ctrl_if #(.NUM_BITS(NB)) bus ();

    rcv_shift_ctrl #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Companion shift register: new bit enters at the MSB, so after NB shifts bit 0 is the first bit received.
    logic [NB-1:0] sr_model = '1;
    always @(posedge clk) if (bus.shift_enable) sr_model <= {bus.sr_serial_in, sr_model[NB-1:1]};
    assign bus.sr_data = sr_model;

    // Strobe and data_ready observation.
    int se_count;
    int se_times[$];
    int dr_rise;
    logic dr_q = 1'b0;
    always @(negedge clk) begin
        if (bus.shift_enable) begin
            se_count = se_count + 1;
            se_times.push_back(cyc);
        end
        if (bus.data_ready && !dr_q) dr_rise = cyc;
        dr_q = bus.data_ready;
    end

    int            frame_start;
    logic          fe_at5;
    int            snap_se_count;
    logic          snap_se, snap_ssi, snap_dr, snap_fe, snap_oe;
    logic [NB-1:0] snap_rx;

    // Drives one frame; iteration c sets the line just after edge frame_start+c.
    task automatic send_frame(input logic [NB-1:0] data, input logic stop_bit, input int read_at, input int abort_at);
        logic [NB+1:0] bits;
        bits = {stop_bit, data, 1'b0};
        se_count = 0;
        se_times.delete();
        dr_rise = -1;
        frame_start = cyc;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (abort_at >= 0 && c >= abort_at) bus.serial_in = 1'b1;
            else bus.serial_in = bits[c / CPB];
            bus.data_read = (c == read_at);
            n_rst = !(abort_at >= 0 && c == abort_at);
            if (c == 5) fe_at5 = bus.framing_error;
            if (abort_at >= 0 && c == abort_at + 1) begin
                snap_se_count = se_count;
                snap_se  = bus.shift_enable;
                snap_ssi = bus.sr_serial_in;
                snap_rx  = bus.rx_data;
                snap_dr  = bus.data_ready;
                snap_fe  = bus.framing_error;
                snap_oe  = bus.overrun_error;
            end
            @(posedge clk); #1;
        end
        bus.data_read = 1'b0;
        bus.serial_in = 1'b1;
        n_rst = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic read_pulse();
        bus.data_read = 1'b1;
        @(posedge clk); #1;
        bus.data_read = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.serial_in = 1'b1;
        bus.data_read = 1'b0;
        idle(2);
        n_rst = 1'b1;
        checks++; if (bus.sr_serial_in !== 1'b1) begin errors++; $display("FAIL rst_sr_serial_in got %b want 1", bus.sr_serial_in); end
        checks++; if (bus.shift_enable !== 1'b0) begin errors++; $display("FAIL rst_shift_enable got %b want 0", bus.shift_enable); end
        checks++; if (bus.rx_data !== 8'hFF) begin errors++; $display("FAIL rst_rx_data got %h want ff", bus.rx_data); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL rst_data_ready got %b want 0", bus.data_ready); end
        checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL rst_framing_error got %b want 0", bus.framing_error); end
        checks++; if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL rst_overrun_error got %b want 0", bus.overrun_error); end
        idle(3);
    endtask

    task automatic test_framing_error();
        send_frame(8'h3C, 1'b0, -1, -1);
        idle(2);
        checks++; if (se_count !== 8) begin errors++; $display("FAIL fe_strobes got %0d want 8", se_count); end
        checks++; if (bus.framing_error !== 1'b1) begin errors++; $display("FAIL fe_flag got %b want 1", bus.framing_error); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL fe_data_ready got %b want 0", bus.data_ready); end
        checks++; if (bus.rx_data !== 8'hFF) begin errors++; $display("FAIL fe_rx_data got %h want ff", bus.rx_data); end
        idle(CPB);
    endtask

    // Line falls after edge n: sync low at n+2, START at n+3, DATA at n+8, strobes high in cycles n+17+10k,
    // stop sampled into LOAD at n+98, data_ready first high after edge n+99.
    task automatic test_frame_a5();
        send_frame(8'hA5, 1'b1, -1, -1);
        idle(2);
        checks++; if (fe_at5 !== 1'b0) begin errors++; $display("FAIL fe_clear_on_start got %b want 0", fe_at5); end
        checks++; if (se_count !== 8) begin errors++; $display("FAIL a5_strobes got %0d want 8", se_count); end
        if (se_times.size() == 8) begin
            checks++; if (se_times[0] !== frame_start + 17) begin errors++; $display("FAIL a5_first_strobe got %0d want %0d", se_times[0] - frame_start, 17); end
            for (int k = 1; k < 8; k++) begin
                checks++; if (se_times[k] - se_times[k-1] !== CPB) begin errors++; $display("FAIL a5_strobe_gap%0d got %0d want %0d", k, se_times[k] - se_times[k-1], CPB); end
            end
        end
        checks++; if (dr_rise !== frame_start + 99) begin errors++; $display("FAIL a5_ready_time got %0d want %0d", dr_rise - frame_start, 99); end
        checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL a5_rx_data got %h want a5", bus.rx_data); end
        checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL a5_data_ready got %b want 1", bus.data_ready); end
        checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL a5_framing_error got %b want 0", bus.framing_error); end
        checks++; if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL a5_overrun_error got %b want 0", bus.overrun_error); end
        read_pulse();
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL a5_read_clears got %b want 0", bus.data_ready); end
        idle(CPB);
    endtask

    task automatic test_false_start();
        se_count = 0;
        bus.serial_in = 1'b0;
        idle(3);
        bus.serial_in = 1'b1;
        idle(4 * CPB);
        checks++; if (se_count !== 0) begin errors++; $display("FAIL false_start_strobes got %0d want 0", se_count); end
        checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL false_start_rx got %h want a5", bus.rx_data); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL false_start_ready got %b want 0", bus.data_ready); end
        checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL false_start_fe got %b want 0", bus.framing_error); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, -1, -1);
        checks++; if (bus.rx_data !== 8'h11) begin errors++; $display("FAIL b2b_first_rx got %h want 11", bus.rx_data); end
        checks++; if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL b2b_first_oe got %b want 0", bus.overrun_error); end
        send_frame(8'h22, 1'b1, -1, -1);
        idle(1);
        checks++; if (bus.rx_data !== 8'h22) begin errors++; $display("FAIL b2b_rx got %h want 22", bus.rx_data); end
        checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", bus.data_ready); end
        checks++; if (bus.overrun_error !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", bus.overrun_error); end
        read_pulse();
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL b2b_read_ready got %b want 0", bus.data_ready); end
        checks++; if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL b2b_read_overrun got %b want 0", bus.overrun_error); end
        idle(CPB);
    endtask

    // Read issued in the cycle after edge n+98, which is the LOAD cycle of the second frame.
    task automatic test_read_in_load();
        send_frame(8'h33, 1'b1, -1, -1);
        checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL ril_first_ready got %b want 1", bus.data_ready); end
        send_frame(8'h5A, 1'b1, 98, -1);
        idle(1);
        checks++; if (bus.rx_data !== 8'h5A) begin errors++; $display("FAIL ril_rx got %h want 5a", bus.rx_data); end
        checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL ril_ready got %b want 1", bus.data_ready); end
        checks++; if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL ril_overrun got %b want 0", bus.overrun_error); end
        idle(CPB);
    endtask

    // Reset driven after edge n+48 (4th strobe was in cycle n+47) is sampled at edge n+49.
    task automatic test_reset_midframe();
        send_frame(8'h96, 1'b1, -1, 48);
        checks++; if (snap_se_count !== 4) begin errors++; $display("FAIL mid_rst_strobes_before got %0d want 4", snap_se_count); end
        checks++; if (snap_se !== 1'b0) begin errors++; $display("FAIL mid_rst_shift_enable got %b want 0", snap_se); end
        checks++; if (snap_ssi !== 1'b1) begin errors++; $display("FAIL mid_rst_sr_serial_in got %b want 1", snap_ssi); end
        checks++; if (snap_rx !== 8'hFF) begin errors++; $display("FAIL mid_rst_rx got %h want ff", snap_rx); end
        checks++; if (snap_dr !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", snap_dr); end
        checks++; if (snap_fe !== 1'b0) begin errors++; $display("FAIL mid_rst_fe got %b want 0", snap_fe); end
        checks++; if (snap_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_oe got %b want 0", snap_oe); end
        checks++; if (se_count !== 4) begin errors++; $display("FAIL mid_rst_strobes_after got %0d want 4", se_count); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_no_load got %b want 0", bus.data_ready); end
        idle(2 * CPB);
        send_frame(8'hC3, 1'b1, -1, -1);
        idle(2);
        checks++; if (se_count !== 8) begin errors++; $display("FAIL c3_strobes got %0d want 8", se_count); end
        checks++; if (bus.rx_data !== 8'hC3) begin errors++; $display("FAIL c3_rx got %h want c3", bus.rx_data); end
        checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL c3_ready got %b want 1", bus.data_ready); end
        checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL c3_fe got %b want 0", bus.framing_error); end
        checks++; if (bus.overrun_error !== 1'b0) begin errors++; $display("FAIL c3_oe got %b want 0", bus.overrun_error); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        se_count = 0;
        dr_rise = -1;
        n_rst = 1'b0;
        bus.serial_in = 1'b1;
        bus.data_read = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_framing_error();
        test_frame_a5();
        test_false_start();
        test_back_to_back();
        test_read_in_load();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
